// File: rtl/ahb_wb_bridge.sv
// rtl/ahb_wb_bridge.sv - AHB-Lite slave to Wishbone master bridge with optional second-memory routing
// One outstanding transfer; errors and ack timeouts answer with the two-cycle AHB ERROR response.
module ahb_wb_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter bit                    SECOND_MEM_EN  = 1'b0,
    parameter logic [ADDR_WIDTH-1:0] DATA_MEM_BASE  = 32'h0008_0000,
    parameter logic [ADDR_WIDTH-1:0] DATA_MEM_MASK  = 32'hFFF8_0000,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hready,
    output logic                    hresp,
    output logic                    core_cyc_o,
    output logic                    core_stb_o,
    output logic                    core_we_o,
    output logic [ADDR_WIDTH-1:0]   core_addr_o,
    output logic [DATA_WIDTH-1:0]   core_data_o,
    output logic [DATA_WIDTH/8-1:0] core_sel_o,
    input  logic [DATA_WIDTH-1:0]   core_data_i,
    input  logic                    core_ack_i,
    output logic                    data_mem_cyc_o,
    output logic                    data_mem_stb_o,
    output logic                    data_mem_we_o,
    output logic [ADDR_WIDTH-1:0]   data_mem_addr_o,
    output logic [DATA_WIDTH-1:0]   data_mem_data_o,
    output logic [DATA_WIDTH/8-1:0] data_mem_sel_o,
    input  logic [DATA_WIDTH-1:0]   data_mem_data_i,
    input  logic                    data_mem_ack_i
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [2:0]              size_q, size_d;
    logic                    dm_q, dm_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

    logic                    ready_state;
    logic                    accept;
    logic                    xfer_err;
    logic                    route_dm;
    logic                    wb_ack;
    logic [DATA_WIDTH-1:0]   wb_rdata;
    logic [NB-1:0]           sel;
    logic                    core_act;
    logic                    dm_act;
    logic                    unused_htrans0;

    function automatic logic misaligned(input logic [2:0] size, input logic [ADDR_WIDTH-1:0] a);
        misaligned = 1'b0;
        for (int i = 0; i < BW; i++) begin
            if (i < int'(size) && a[i]) misaligned = 1'b1;
        end
    endfunction

    function automatic logic [NB-1:0] byte_sel(input logic [2:0] size, input logic [ADDR_WIDTH-1:0] a);
        int off;
        int n;
        off = int'(a[BW-1:0]);
        n   = 1 << size;
        for (int i = 0; i < NB; i++) begin
            byte_sel[i] = (i >= off) && (i < off + n);
        end
    endfunction

    assign unused_htrans0 = htrans[0];

    assign ready_state = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
    assign accept      = htrans[1] && ready_state;
    assign xfer_err    = (hsize > 3'(BW)) || misaligned(hsize, haddr);
    assign route_dm    = SECOND_MEM_EN && ((haddr & DATA_MEM_MASK) == DATA_MEM_BASE);
    assign wb_ack      = dm_q ? data_mem_ack_i : core_ack_i;
    assign wb_rdata    = dm_q ? data_mem_data_i : core_data_i;
    assign sel         = byte_sel(size_q, addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            dm_q     <= 1'b0;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            dm_q     <= dm_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        dm_d     = dm_q;
        cnt_d    = cnt_q;
        hrdata_d = hrdata_q;
        case (state_q)
            IDLE, DONE, ERR2: begin
                if (accept) begin
                    addr_d  = haddr;
                    we_d    = hwrite;
                    size_d  = hsize;
                    dm_d    = route_dm;
                    cnt_d   = '0;
                    state_d = xfer_err ? ERR1 : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // ack takes priority over a timeout landing in the same cycle
                if (wb_ack) begin
                    state_d = DONE;
                    if (!we_q) hrdata_d = wb_rdata;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ERR1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    assign core_act = (state_q == WAIT) && !dm_q;
    assign dm_act   = (state_q == WAIT) && dm_q;

    assign hready = ready_state;
    assign hresp  = (state_q == ERR1) || (state_q == ERR2);
    assign hrdata = hrdata_q;

    assign core_cyc_o      = core_act;
    assign core_stb_o      = core_act;
    assign core_we_o       = core_act && we_q;
    assign core_addr_o     = core_act ? addr_q : '0;
    assign core_sel_o      = core_act ? sel : '0;
    assign core_data_o     = core_act ? hwdata : '0;

    assign data_mem_cyc_o  = dm_act;
    assign data_mem_stb_o  = dm_act;
    assign data_mem_we_o   = dm_act && we_q;
    assign data_mem_addr_o = dm_act ? addr_q : '0;
    assign data_mem_sel_o  = dm_act ? sel : '0;
    assign data_mem_data_o = dm_act ? hwdata : '0;

endmodule

// File: tb/tb_ahb_wb_bridge.sv
// tb/tb_ahb_wb_bridge.sv - self-checking bench for ahb_wb_bridge against a transfer-level model
module tb_ahb_wb_bridge;

    localparam logic [31:0] BASE = 32'h0008_0000;
    localparam logic [31:0] MASK = 32'hFFF8_0000;
    localparam int          TO   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        core_cyc_o, core_stb_o, core_we_o;
    logic [31:0] core_addr_o, core_data_o, core_data_i;
    logic [3:0]  core_sel_o;
    logic        core_ack_i;
    logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
    logic [31:0] data_mem_addr_o, data_mem_data_o, data_mem_data_i;
    logic [3:0]  data_mem_sel_o;
    logic        data_mem_ack_i;

    ahb_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SECOND_MEM_EN(1'b1),
        .DATA_MEM_BASE(BASE), .DATA_MEM_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .core_cyc_o(core_cyc_o), .core_stb_o(core_stb_o), .core_we_o(core_we_o),
        .core_addr_o(core_addr_o), .core_data_o(core_data_o), .core_sel_o(core_sel_o),
        .core_data_i(core_data_i), .core_ack_i(core_ack_i),
        .data_mem_cyc_o(data_mem_cyc_o), .data_mem_stb_o(data_mem_stb_o),
        .data_mem_we_o(data_mem_we_o), .data_mem_addr_o(data_mem_addr_o),
        .data_mem_data_o(data_mem_data_o), .data_mem_sel_o(data_mem_sel_o),
        .data_mem_data_i(data_mem_data_i), .data_mem_ack_i(data_mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          resp;
        bit          act;
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mrd;
    bit          tail_resp;
    int          m_core, m_dm, m_self, m_resp, m_rdy0;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [31:0] cap_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t rec(input bit rdy, input bit resp);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.act = 1'b0; e.dm = 1'b0; e.we = 1'b0;
        e.addr = '0; e.sel = '0; e.wd = '0; e.rd = mrd;
        return e;
    endfunction

    // Cycle-accurate comparison of every output against the model's queued expectation
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("hready", hready, e.rdy);
            chk("hresp", hresp, e.resp);
            chk("hrdata", hrdata, e.rd);
            chk("core_cyc", core_cyc_o, e.act && !e.dm);
            chk("core_stb", core_stb_o, e.act && !e.dm);
            chk("dm_cyc", data_mem_cyc_o, e.act && e.dm);
            chk("dm_stb", data_mem_stb_o, e.act && e.dm);
            if (e.act && !e.dm) begin
                chk("core_we", core_we_o, e.we);
                chk("core_addr", core_addr_o, e.addr);
                chk("core_sel", core_sel_o, e.sel);
                chk("core_data", core_data_o, e.wd);
            end
            if (e.act && e.dm) begin
                chk("dm_we", data_mem_we_o, e.we);
                chk("dm_addr", data_mem_addr_o, e.addr);
                chk("dm_sel", data_mem_sel_o, e.sel);
                chk("dm_data", data_mem_data_o, e.wd);
            end
        end
    end

    always @(negedge clk) begin
        if (core_cyc_o) begin
            m_core++;
            cap_sel  = core_sel_o;
            cap_we   = core_we_o;
            cap_data = core_data_o;
            if (core_sel_o == 4'hF) m_self++;
        end
        if (data_mem_cyc_o) m_dm++;
        if (hresp) m_resp++;
        if (!hready) m_rdy0++;
    end

    task automatic clr();
        m_core = 0; m_dm = 0; m_self = 0; m_resp = 0; m_rdy0 = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        core_ack_i      = 1'b0;
        data_mem_ack_i  = 1'b0;
        core_data_i     = 32'h0BAD_C0DE;
        data_mem_data_i = 32'h0BAD_D00D;
    endtask

    task automatic emit(input exp_t e);
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        next();
        htrans = 2'b00;
        emit(rec(1'b1, tail_resp));
        tail_resp = 1'b0;
    endtask

    // dly = WAIT cycles without ack before the acking one; negative means never ack
    task automatic xfer(input logic [31:0] a, input int sz, input bit wr,
                        input logic [31:0] wd, input int dly, input logic [31:0] rd);
        exp_t e;
        bit   dm;
        bit   err;
        int   n;
        int   s;
        dm  = ((a & MASK) == BASE);
        err = (sz > 2) || ((a % (32'd1 << sz)) != 0);
        next();
        haddr = a; htrans = 2'b10; hwrite = wr; hsize = 3'(sz);
        emit(rec(1'b1, tail_resp));
        next();
        htrans = 2'b00; haddr = 32'hFFFF_FFFC; hwrite = ~wr; hsize = 3'd7; hwdata = wd;
        if (err) begin
            emit(rec(1'b0, 1'b1));
            tail_resp = 1'b1;
            return;
        end
        s = ((1 << (1 << sz)) - 1) << (a % 4);
        n = 0;
        forever begin
            e = rec(1'b0, 1'b0);
            e.act = 1'b1; e.dm = dm; e.we = wr; e.addr = a; e.sel = s[3:0]; e.wd = wd;
            if (dm) begin
                data_mem_ack_i = (n == dly); data_mem_data_i = rd; core_ack_i = 1'b1;
            end else begin
                core_ack_i = (n == dly); core_data_i = rd; data_mem_ack_i = 1'b1;
            end
            emit(e);
            if (n == dly) begin
                if (!wr) mrd = rd;
                tail_resp = 1'b0;
                break;
            end
            if (n == TO - 1) begin
                next();
                emit(rec(1'b0, 1'b1));
                tail_resp = 1'b1;
                break;
            end
            n++;
            next();
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        core_ack_i = 1'b0; data_mem_ack_i = 1'b0; core_data_i = '0; data_mem_data_i = '0;
        mrd = '0; tail_resp = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hready", hready, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_core_cyc", core_cyc_o, 1'b0);
        chk("rst_core_sel", core_sel_o, 4'h0);
        chk("rst_core_addr", core_addr_o, 32'h0);
        chk("rst_core_we", core_we_o, 1'b0);
        chk("rst_dm_cyc", data_mem_cyc_o, 1'b0);
        rst = 1'b0;

        clr();
        xfer(32'h40, 2, 1'b0, 32'h0, 2, 32'hDEADBEEF);
        idle();
        chk("word_rd_hrdata", hrdata, 32'hDEADBEEF);
        chk("word_rd_hready", hready, 1'b1);
        idle();
        chk("word_rd_sel_cycles", m_self, 3);

        clr();
        xfer(32'h103, 0, 1'b1, 32'hAA00_0000, 0, 32'h0);
        idle(); idle();
        chk("byte_wr_sel", cap_sel, 4'h8);
        chk("byte_wr_we", cap_we, 1'b1);
        chk("byte_wr_data", cap_data, 32'hAA00_0000);
        chk("byte_wr_cycles", m_core, 1);

        clr();
        xfer(32'h0008_0010, 2, 1'b0, 32'h0, 1, 32'h1111_2222);
        idle(); idle();
        chk("route_dm_dm", m_dm, 2);
        chk("route_dm_core", m_core, 0);
        clr();
        xfer(32'h0000_0010, 2, 1'b0, 32'h0, 1, 32'h3333_4444);
        idle(); idle();
        chk("route_core_core", m_core, 2);
        chk("route_core_dm", m_dm, 0);

        clr();
        xfer(32'h42, 2, 1'b0, 32'h0, 0, 32'h0);
        idle(); idle();
        chk("misalign_resp_cycles", m_resp, 2);
        chk("misalign_wait_cycles", m_rdy0, 1);
        chk("misalign_no_cyc", m_core + m_dm, 0);

        xfer(32'h2, 1, 1'b1, 32'hBEEF_0000, 0, 32'h0);
        xfer(32'h0, 3, 1'b0, 32'h0, 0, 32'h0);
        xfer(32'h0008_0004, 2, 1'b1, 32'h5A5A_A5A5, 1, 32'h0);
        idle();

        clr();
        xfer(32'h80, 2, 1'b0, 32'h0, -1, 32'h0);
        idle(); idle();
        chk("timeout_cyc_cycles", m_core, TO);
        chk("timeout_resp_cycles", m_resp, 2);
        xfer(32'h84, 2, 1'b0, 32'h0, TO - 1, 32'h5555_6666);
        idle();
        chk("ack_at_limit_hrdata", hrdata, 32'h5555_6666);

        clr();
        xfer(32'h100, 2, 1'b0, 32'h0, 0, 32'hA1A1_A1A1);
        xfer(32'h104, 2, 1'b0, 32'h0, 0, 32'hB2B2_B2B2);
        idle();
        chk("b2b_hrdata", hrdata, 32'hB2B2_B2B2);
        idle();
        chk("b2b_wait_cycles", m_rdy0, 2);
        chk("b2b_cyc_cycles", m_core, 2);

        next();
        haddr = 32'h200; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        emit(rec(1'b1, tail_resp));
        next();
        htrans = 2'b00; hwdata = 32'h0; rst = 1'b1;
        e = rec(1'b0, 1'b0);
        e.act = 1'b1; e.addr = 32'h200; e.sel = 4'hF;
        emit(e);
        next();
        rst = 1'b0; mrd = '0; tail_resp = 1'b0;
        core_ack_i = 1'b1; core_data_i = 32'h1234_5678;
        emit(rec(1'b1, 1'b0));
        chk("rst_wait_cyc", core_cyc_o, 1'b0);
        chk("rst_wait_hready", hready, 1'b1);
        next();
        core_ack_i = 1'b1; core_data_i = 32'h1234_5678;
        emit(rec(1'b1, 1'b0));
        chk("late_ack_hrdata", hrdata, 32'h0);
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
